instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 22 ++
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction memory read bus between the fetch unit and memory.
// master = fetch side, slave = memory side.
interface instr_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Thumb halfword fetch unit: word reads from memory, halfwords to decode.
// Define INSTR_FETCH_WORD_REUSE_EN to serve both halfwords from one read.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  instr_fetch_if.master mem,
  output logic [15:0]  instruction,
  output logic [31:0]  PC_out,
  output logic         instr_valid,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    OUT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] word_buf;
  logic        flush;

  logic [31:0] tgt;
  logic [31:0] pc_nxt;

  assign tgt    = branch_target & 32'hFFFF_FFFE;
  assign pc_nxt = pc + 32'd2;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      word_buf     <= '0;
      flush        <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      instruction  <= '0;
      PC_out       <= '0;
      instr_valid  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state       <= REQ;
          mem.mem_req <= 1'b1;
          if (branch_taken) begin
            pc           <= tgt;
            mem.mem_addr <= word_of(tgt);
          end else begin
            mem.mem_addr <= word_of(pc);
          end
        end
        REQ: begin
          if (branch_taken) begin
            pc          <= tgt;
            word_buf    <= '0;
            instr_valid <= 1'b0;
            // an ack now ends the old read; otherwise it is still owed
            if (mem.mem_ack) begin
              flush        <= 1'b0;
              mem.mem_addr <= word_of(tgt);
            end else begin
              flush <= 1'b1;
            end
          end else if (mem.mem_ack) begin
            if (flush) begin
              flush        <= 1'b0;
              mem.mem_addr <= word_of(pc);
            end else begin
              state       <= OUT;
              mem.mem_req <= 1'b0;
              word_buf    <= mem.mem_rdata;
              instruction <= pc[1] ? mem.mem_rdata[31:16]
                                   : mem.mem_rdata[15:0];
              PC_out      <= pc;
              instr_valid <= 1'b1;
            end
          end
        end
        OUT: begin
          if (branch_taken) begin
            pc           <= tgt;
            word_buf     <= '0;
            instr_valid  <= 1'b0;
            state        <= REQ;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= word_of(tgt);
          end else if (!stall) begin
            pc <= pc_nxt;
`ifdef INSTR_FETCH_WORD_REUSE_EN
            if (!pc[1]) begin
              instruction <= word_buf[31:16];
              PC_out      <= pc_nxt;
            end else begin
              instr_valid  <= 1'b0;
              state        <= REQ;
              mem.mem_req  <= 1'b1;
              mem.mem_addr <= word_of(pc_nxt);
            end
`else
            instr_valid  <= 1'b0;
            state        <= REQ;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= word_of(pc_nxt);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: memory responder plus a
// program-order model of the halfword stream the decoder must see.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instruction;
  logic [31:0] PC_out;
  logic        instr_valid;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;

  instr_fetch_if mem ();

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem           (mem),
    .instruction   (instruction),
    .PC_out        (PC_out),
    .instr_valid   (instr_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory contents: a fixed hash of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hBBBB_AAAA ^ ((a & 32'hFFFF_FFFC) * 32'h9E37_79B1);
  endfunction

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // model: program counter of the next halfword the decoder should see
  logic [31:0] mpc;
  bit          stale;
  bit          pending;
  int          cnt;
  logic [31:0] req_addr;

  bit          p_valid, p_stall, p_branch, p_req, p_ack;
  logic [31:0] p_tgt, p_pcout;
  logic [15:0] p_instr;

  int stall_pct, br_pct, max_lat, spur_pct;
  bit fixed_lat;

  task automatic model_reset();
    mpc      = 32'h0;
    stale    = 1'b0;
    pending  = 1'b0;
    cnt      = 0;
    req_addr = '0;
    p_valid  = 1'b0;
    p_stall  = 1'b0;
    p_branch = 1'b0;
    p_req    = 1'b0;
    p_ack    = 1'b0;
    p_tgt    = '0;
    p_pcout  = '0;
    p_instr  = '0;
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0: return 32'h0000_0103;
      1: return 32'hFFFF_FFFF;
      2: return 32'hFFFF_FFFC;
      default: return $urandom;
    endcase
  endfunction

  task automatic step();
    bit          c_valid, c_req, ack;
    logic [31:0] old, rdata;
    c_valid = instr_valid;
    c_req   = mem.mem_req;
    old     = mpc;

    if (p_branch) begin
      mpc = p_tgt & 32'hFFFF_FFFE;
      check("valid_after_branch", {31'd0, c_valid}, 32'd0);
      if (p_req) stale = !p_ack;
    end else begin
      if (p_valid && !p_stall) begin
        mpc = mpc + 32'd2;
`ifdef INSTR_FETCH_WORD_REUSE_EN
        check("reuse_valid", {31'd0, c_valid}, {31'd0, !old[1]});
`else
        check("refetch_valid", {31'd0, c_valid}, 32'd0);
`endif
      end else if (p_valid && p_stall) begin
        check("hold_valid", {31'd0, c_valid}, 32'd1);
        check("hold_instr", {16'd0, instruction}, {16'd0, p_instr});
        check("hold_pc", PC_out, p_pcout);
      end
      if (p_req && p_ack) begin
        if (stale) begin
          stale = 1'b0;
          check("flushed_ack", {31'd0, c_valid}, 32'd0);
        end else begin
          check("ack_valid", {31'd0, c_valid}, 32'd1);
        end
      end
    end

    if (c_valid) begin
      check("pc_out", PC_out, mpc);
      check("instr", {16'd0, instruction}, {16'd0, half_at(mpc)});
    end

    ack   = 1'b0;
    rdata = $urandom;
    if (c_req) begin
      check("addr_align", {30'd0, mem.mem_addr[1:0]}, 32'd0);
      if (!pending) begin
        pending  = 1'b1;
        req_addr = mem.mem_addr;
        check("req_addr", mem.mem_addr, mpc & 32'hFFFF_FFFC);
        cnt = fixed_lat ? 1 : $urandom_range(0, max_lat);
      end else begin
        check("addr_stable", mem.mem_addr, req_addr);
      end
      if (cnt == 0) begin
        ack     = 1'b1;
        rdata   = mem_word(req_addr);
        pending = 1'b0;
      end else begin
        cnt--;
      end
    end else begin
      pending = 1'b0;
      if ($urandom_range(0, 99) < spur_pct) ack = 1'b1;
    end

    mem.mem_ack   = ack;
    mem.mem_rdata = rdata;
    stall         = $urandom_range(0, 99) < stall_pct;
    branch_taken  = $urandom_range(0, 99) < br_pct;
    branch_target = pick_target();

    p_valid  = c_valid;
    p_stall  = stall;
    p_branch = branch_taken;
    p_req    = c_req;
    p_ack    = ack;
    p_tgt    = branch_target;
    p_pcout  = PC_out;
    p_instr  = instruction;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'd0, mem.mem_req}, 32'd0);
    check({tag, "_addr"}, mem.mem_addr, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"}, {16'd0, instruction}, 32'd0);
    check({tag, "_pc"}, PC_out, 32'd0);
  endtask

  // release reset with a stray ack present while the unit sits in IDLE
  task automatic release_reset();
    reset         = 1'b0;
    model_reset();
    mem.mem_ack   = 1'b1;
    mem.mem_rdata = 32'hDEAD_BEEF;
    stall         = 1'b0;
    branch_taken  = 1'b0;
  endtask

  initial begin
    int rst_at;
    mem.mem_ack   = 1'b0;
    mem.mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    release_reset();
    rst_at = 800;

    for (int i = 0; i < 3000; i++) begin
      if (i < 30) begin
        stall_pct = 0; br_pct = 0; spur_pct = 0;
        max_lat = 1; fixed_lat = 1'b1;
      end else begin
        stall_pct = 40; br_pct = 10; spur_pct = 20;
        max_lat = 3; fixed_lat = 1'b0;
      end
      @(negedge clk);
      step();
      if (i >= rst_at && mem.mem_req) begin
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        check_reset_outputs("held_reset");
        release_reset();
        rst_at += 1000;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
